pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with valid/ready flow control, an optional skid entry, synchronous flush, and bubble-safe control gating. It is the generic replacement for the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) between datapath stages. It carries a control field, which is forced to zero whenever the stage holds no valid beat, and an opaque data payload. Hazard/stall logic drives `out_ready` and `flush` instead of per-stage enables.

## Interface
Parameters:
- `CTRL_W`, 5: control-bit field width; zeroed on bubbles.
- `DATA_W`, 106: payload width (e.g. EX/MEM: Add 32 + Zero 1 + ALUResult 32 + ReadData2 32 + dest reg 5, padded).
- `SKID`, 1: 1 adds a second (skid) entry with registered `in_ready`; 0 gives a single entry with pass-through ready.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  kill all held beats and the beat offered this cycle.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat.
- `in_ctrl`  in  CTRL_W  upstream control bits.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  downstream beat present.
- `out_ready`  in  1  downstream accepts (0 = stall).
- `out_ctrl`  out  CTRL_W  control bits; 0 when `out_valid`=0.
- `out_data`  out  DATA_W  payload; holds last value when invalid.
- `occupancy`  out  2  number of held beats (0..2; max 1 when SKID=0).

## Operation
- A transfer occurs on a posedge where `valid && ready` is true on that side.
- Main entry drives the outputs. `out_ctrl = main_valid ? main_ctrl : 0`.
- SKID=1:
  - `in_ready` is registered and equals `!skid_valid`.
  - An accepted beat goes to main if main is empty or is draining this cycle. Otherwise it goes to skid.
  - When main drains and skid is full, skid moves to main and skid empties.
  - Beat order is always preserved.
- SKID=0:
  - `in_ready = !reset && (!main_valid || out_ready)`, combinational.
  - An accepted beat overwrites main.
- Flush:
  - On the next posedge, main_valid and skid_valid are cleared and any beat offered that cycle is discarded.
  - `out_ctrl` reads 0 the following cycle; data registers keep their values.
  - Flush overrides a simultaneous accept and a simultaneous drain. The downstream handshake still completes: the downstream stage owns the beat it accepted in that cycle.
- Reset:
  - On the next posedge, all valid bits, ctrl and data registers are set to 0.
  - Reset overrides flush and all handshakes.
  - While reset is high, `in_ready`=0.
- Simultaneous accept and drain with main full and skid empty: the new beat goes into main. Throughput stays 1 beat/cycle with no bubble.
- Accept attempts while `in_ready`=0 are ignored. Upstream must hold `in_valid` and data stable until accepted.

## Timing
- Reset values:
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0.
  - `in_ready`=0 during reset, and 1 on the first cycle after reset deasserts.
- Latency: a beat accepted at edge N appears on `out_*` after edge N (1 cycle).
- Throughput: 1 beat/cycle with `out_ready` held high, in both modes.
- SKID=1 has no combinational path from `out_ready` to `in_ready`. SKID=0 does have one.
- With `out_ready`=0, SKID=1 absorbs exactly 2 beats. `in_ready` falls the cycle after the second accept.
- `occupancy` updates on the same edge as the valid bits.

## Structure
- Shared package `pipe_pkg` holds:
  - control-bit index constants: BRANCH=0, MEMREAD=1, MEMTOREG=2, MEMWRITE=3, REGWRITE=4, and EXMEM_CTRL_W=5;
  - per-stage payload width constants.
- One sub-module `pipe_slot` holds valid, ctrl and data with load and clear strobes. It is instantiated as main and, when SKID=1, as skid. The enclosing FSM-like steering logic stays in `pipe_stage_reg`.

## Test plan
- **Reset:** assert `reset` 2 cycles with `in_valid`=1, `in_ctrl`=5'h1F → `out_valid`=0, `out_ctrl`=0, `in_ready`=0; the cycle after release `in_ready`=1 and `occupancy`=0.
- **Streaming:** SKID=1, `out_ready`=1, 8 back-to-back beats with data 1..8 and ctrl 5'h11 → outputs 1..8 on consecutive cycles, each 1 cycle after its accept, with no bubbles.
- **Stall fill and drain:** SKID=1, `out_ready`=0, offer A, B, C → A and B accepted, `occupancy`=2, `in_ready`=0, C held. Release `out_ready` → outputs A, B, C in order.
- **Flush:** `occupancy`=2 with ctrl 5'h18, assert `flush` while offering D → the next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, and D never appears.
- **Flush with reset:** assert `flush` and `reset` together with a beat held → `out_data`=0 (reset wins), not the retained payload.
- **SKID=0 stall:** `out_ready`=0 with main full → `in_ready`=0 in the same cycle. Raise `out_ready` with `in_valid`=1 → drain and accept on one edge, `occupancy` stays 1.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage constants: control-bit positions of the EX/MEM control
// field and payload widths for each inter-stage register.
package pipe_pkg;

  // Control-bit index constants (EX/MEM control field)
  localparam int BRANCH       = 0;
  localparam int MEMREAD      = 1;
  localparam int MEMTOREG     = 2;
  localparam int MEMWRITE     = 3;
  localparam int REGWRITE     = 4;
  localparam int EXMEM_CTRL_W = 5;

  // Per-stage payload widths
  localparam int IFID_DATA_W  = 64;   // pc 32 + instr 32
  localparam int IDEX_DATA_W  = 133;  // pc 32 + rd1 32 + rd2 32 + imm 32 + rd 5
  localparam int EXMEM_DATA_W = 106;  // add 32 + zero 1 + alu 32 + rd2 32 + rd 5, padded
  localparam int MEMWB_DATA_W = 69;   // read data 32 + alu 32 + rd 5

  // Beat count from the two entry valid bits
  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline entry (valid, ctrl, data) with load and clear strobes; clear wins over load.
// Registered, 1-cycle update; no flow control of its own, the enclosing stage steers it.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Clear only drops the valid bit; ctrl/data keep their last contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register, optional skid entry, flush, control zeroed on bubbles.
// 1-cycle latency, 1 beat/cycle; SKID=1 registers in_ready, SKID=0 passes out_ready through.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic              accept;
  logic              drain;
  logic              main_load;
  logic              main_clear;
  logic              main_from_skid;
  logic              skid_load;
  logic              skid_clear;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;

  assign accept = in_valid && in_ready;
  assign drain  = main_valid && out_ready;

  // Steering: skid (when present) always refills main first to preserve order.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (skid_valid && drain) begin
      main_load      = 1'b1;
      main_from_skid = 1'b1;
      skid_clear     = 1'b1;
    end else if (accept && (!main_valid || drain)) begin
      main_load = 1'b1;
    end else if (accept) begin
      skid_load = 1'b1;
    end else if (drain) begin
      main_clear = 1'b1;
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_data;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .clear     (main_clear),
    .load_ctrl (main_d_ctrl),
    .load_data (main_d_data),
    .valid     (main_valid),
    .ctrl      (main_ctrl),
    .data      (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_ctrl (in_ctrl),
        .load_data (in_data),
        .valid     (skid_valid),
        .ctrl      (skid_ctrl),
        .data      (skid_data)
      );
      // Depends only on a register and reset, so out_ready never reaches in_ready.
      assign in_ready = !reset && !skid_valid;
    end else begin : g_noskid
      logic unused_skid_strobes;
      assign unused_skid_strobes = skid_load ^ skid_clear;
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready   = !reset && (!main_valid || out_ready);
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = occ_count(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg (SKID=1) plus hand sequences for reset,
// flush-with-reset and the SKID=0 pass-through ready.
module tb_pipe_stage_reg;

  localparam int CW = 5;
  localparam int DW = 106;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;

  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  logic          in_valid0;
  logic [CW-1:0] in_ctrl0;
  logic [DW-1:0] in_data0;
  logic          out_ready0;
  logic          in_ready0;
  logic          out_valid0;
  logic [CW-1:0] out_ctrl0;
  logic [DW-1:0] out_data0;
  logic [1:0]    occupancy0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .in_ctrl   (in_ctrl0),
    .in_data   (in_data0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .out_ctrl  (out_ctrl0),
    .out_data  (out_data0),
    .occupancy (occupancy0)
  );

  typedef struct {
    logic          iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    logic          ordy;
    logic          fl;
    logic          e_ov;
    logic [CW-1:0] e_oc;
    logic [DW-1:0] e_od;
    logic [1:0]    e_occ;
    logic          e_ir;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                              input logic ordy, input logic fl, input logic e_ov,
                              input logic [CW-1:0] e_oc, input logic [DW-1:0] e_od,
                              input logic [1:0] e_occ, input logic e_ir);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_oc = e_oc; v.e_od = e_od; v.e_occ = e_occ; v.e_ir = e_ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_ctrl = 5'h1F; in_data = 106'hAA; out_ready = 1'b1;
    in_valid0 = 1'b1; in_ctrl0 = 5'h1F; in_data0 = 106'hBB; out_ready0 = 1'b1;

    // Streaming 1..8, ctrl 11
    for (int k = 0; k < 8; k++)
      vecs[k] = mk(1'b1, 5'h11, DW'(k + 1), 1'b1, 1'b0, 1'b1, 5'h11, DW'(k + 1), 2'd1, 1'b1);
    vecs[8]  = mk(1'b0, 5'h00, 106'h0,  1'b1, 1'b0, 1'b0, 5'h00, 106'h8,  2'd0, 1'b1);
    // Stall fill with A, B; C refused; then drain in order
    vecs[9]  = mk(1'b1, 5'h18, 106'hA,  1'b0, 1'b0, 1'b1, 5'h18, 106'hA,  2'd1, 1'b1);
    vecs[10] = mk(1'b1, 5'h18, 106'hB,  1'b0, 1'b0, 1'b1, 5'h18, 106'hA,  2'd2, 1'b0);
    vecs[11] = mk(1'b1, 5'h18, 106'hC,  1'b0, 1'b0, 1'b1, 5'h18, 106'hA,  2'd2, 1'b0);
    vecs[12] = mk(1'b1, 5'h18, 106'hC,  1'b1, 1'b0, 1'b1, 5'h18, 106'hB,  2'd1, 1'b1);
    vecs[13] = mk(1'b1, 5'h18, 106'hC,  1'b1, 1'b0, 1'b1, 5'h18, 106'hC,  2'd1, 1'b1);
    vecs[14] = mk(1'b0, 5'h00, 106'h0,  1'b1, 1'b0, 1'b0, 5'h00, 106'hC,  2'd0, 1'b1);
    // Flush with both entries full while D is offered
    vecs[15] = mk(1'b1, 5'h18, 106'h11, 1'b0, 1'b0, 1'b1, 5'h18, 106'h11, 2'd1, 1'b1);
    vecs[16] = mk(1'b1, 5'h18, 106'h12, 1'b0, 1'b0, 1'b1, 5'h18, 106'h11, 2'd2, 1'b0);
    vecs[17] = mk(1'b1, 5'h1F, 106'hD,  1'b0, 1'b1, 1'b0, 5'h00, 106'h11, 2'd0, 1'b1);
    vecs[18] = mk(1'b0, 5'h00, 106'h0,  1'b1, 1'b0, 1'b0, 5'h00, 106'h11, 2'd0, 1'b1);
    // Flush against a simultaneous accept and drain
    vecs[19] = mk(1'b1, 5'h18, 106'h13, 1'b0, 1'b0, 1'b1, 5'h18, 106'h13, 2'd1, 1'b1);
    vecs[20] = mk(1'b1, 5'h1F, 106'hD,  1'b1, 1'b1, 1'b0, 5'h00, 106'h13, 2'd0, 1'b1);
    vecs[21] = mk(1'b0, 5'h00, 106'h0,  1'b1, 1'b0, 1'b0, 5'h00, 106'h13, 2'd0, 1'b1);

    // Reset held two cycles with a beat offered
    for (int r = 0; r < 2; r++) begin
      cyc();
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_out_ctrl",  128'(out_ctrl),  128'(5'h0));
      chk("rst_out_data",  128'(out_data),  128'(106'h0));
      chk("rst_in_ready",  128'(in_ready),  128'(1'b0));
      chk("rst_in_ready0", 128'(in_ready0), 128'(1'b0));
    end
    reset = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
    #1;
    chk("post_rst_in_ready",  128'(in_ready),   128'(1'b1));
    chk("post_rst_occ",       128'(occupancy),  128'(2'd0));
    chk("post_rst_in_ready0", 128'(in_ready0),  128'(1'b1));
    chk("post_rst_occ0",      128'(occupancy0), 128'(2'd0));

    foreach (vecs[i]) begin
      in_valid = vecs[i].iv; in_ctrl = vecs[i].ic; in_data = vecs[i].id;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      cyc();
      chk($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].e_ov));
      chk($sformatf("v%0d_out_ctrl", i),  128'(out_ctrl),  128'(vecs[i].e_oc));
      chk($sformatf("v%0d_out_data", i),  128'(out_data),  128'(vecs[i].e_od));
      chk($sformatf("v%0d_occ", i),       128'(occupancy), 128'(vecs[i].e_occ));
      chk($sformatf("v%0d_in_ready", i),  128'(in_ready),  128'(vecs[i].e_ir));
    end
    flush = 1'b0; in_valid = 1'b0;

    // Flush and reset together: reset clears the retained payload
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 5'h18; in_data = 106'h77;
    cyc();
    chk("fr_load_data", 128'(out_data), 128'(106'h77));
    in_valid = 1'b0; flush = 1'b1; reset = 1'b1;
    cyc();
    chk("fr_out_data",  128'(out_data),  128'(106'h0));
    chk("fr_out_valid", 128'(out_valid), 128'(1'b0));
    chk("fr_occ",       128'(occupancy), 128'(2'd0));
    flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
    cyc();

    // SKID=0: combinational ready, drain and accept on one edge
    out_ready0 = 1'b0; in_valid0 = 1'b1; in_ctrl0 = 5'h04; in_data0 = 106'h21;
    cyc();
    chk("s0_load_data",   128'(out_data0),  128'(106'h21));
    chk("s0_load_occ",    128'(occupancy0), 128'(2'd1));
    in_data0 = 106'h22;
    #1;
    chk("s0_stall_ready", 128'(in_ready0),  128'(1'b0));
    out_ready0 = 1'b1;
    #1;
    chk("s0_pass_ready",  128'(in_ready0),  128'(1'b1));
    cyc();
    chk("s0_swap_data",   128'(out_data0),  128'(106'h22));
    chk("s0_swap_ctrl",   128'(out_ctrl0),  128'(5'h04));
    chk("s0_swap_occ",    128'(occupancy0), 128'(2'd1));
    chk("s0_swap_valid",  128'(out_valid0), 128'(1'b1));
    in_valid0 = 1'b0;
    cyc();
    chk("s0_empty_valid", 128'(out_valid0), 128'(1'b0));
    chk("s0_empty_ctrl",  128'(out_ctrl0),  128'(5'h0));
    chk("s0_empty_occ",   128'(occupancy0), 128'(2'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
